mat_ops_seq: RTL and testbench

Parametrised, sequential N×N matrix operation unit: elementwise add and subtract, transpose of A, and matrix multiply A×B on unsigned W-bit elements. Operands are latched on a start/busy/done handshake, and the result is computed over multiple cycles by a single multiply-accumulate datapath. It supersedes the fixed 4×4 combinational matrix ALU for designs that need larger matrices or lower area, and sits between the operand register bank and the result consumer.

---
 rtl/mat_ops_pkg.sv | 23 ++
 rtl/mat_ops_seq_mac.sv | 38 +++
 rtl/mat_ops_seq.sv | 157 +++++++++++++++
 tb/tb_mat_ops_seq.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mat_ops_pkg.sv
// Shared types and helpers for the sequential matrix operation unit.
package mat_ops_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_TRN = 2'd2,
    OP_MUL = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Row 0 / col 0 lives in the MSBs of the flat bus.
  function automatic int unsigned elem_off(input int unsigned r, input int unsigned c,
                                           input int unsigned n, input int unsigned w);
    return (n * n - 1 - (r * n + c)) * w;
  endfunction

endpackage

// File: rtl/mat_ops_seq_mac.sv
// Single W x W multiply-accumulate stage with clear-on-first-term and overflow flag.
module mat_mac
  import mat_ops_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] sum,
  output logic         big
);

  localparam int unsigned AW = 2 * W + $clog2(N);

  logic [AW-1:0]  acc;
  logic [AW-1:0]  total;
  logic [2*W-1:0] prod;

  assign prod  = {{W{1'b0}}, x} * {{W{1'b0}}, y};
  // clr discards the stale accumulator so the first term starts a new dot product
  assign total = (clr ? '0 : acc) + AW'(prod);
  assign sum   = total[W-1:0];
  assign big   = |total[AW-1:W];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= total;
    end
  end

endmodule

// File: rtl/mat_ops_seq.sv
// Sequential N x N matrix unit: ADD/SUB/TRN one row per cycle, MUL one MAC per cycle.
module mat_ops_seq
  import mat_ops_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [N*N*W-1:0] a,
  input  logic [N*N*W-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [N*N*W-1:0] result,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(N);
  localparam int unsigned FW = N * N * W;
  localparam int unsigned IW = $clog2(FW);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t         state;
  op_t            op_q;
  logic [FW-1:0]  a_q;
  logic [FW-1:0]  b_q;
  logic [FW-1:0]  work;
  logic           work_ovf;
  logic [CW-1:0]  row;
  logic [CW-1:0]  col;
  logic [CW-1:0]  kk;

  logic [W-1:0]   row_data [N];
  logic           row_ovf;
  logic [W:0]     ext;
  logic [W-1:0]   mac_sum;
  logic           mac_big;
  logic           mac_en;

  function automatic logic [IW-1:0] off(input logic [CW-1:0] r, input logic [CW-1:0] c);
    return IW'(elem_off(32'(r), 32'(c), N, W));
  endfunction

  always_comb begin
    row_ovf = 1'b0;
    ext     = '0;
    for (int unsigned cc = 0; cc < N; cc++) begin
      row_data[CW'(cc)] = '0;
      case (op_q)
        OP_ADD: begin
          ext = {1'b0, a_q[off(row, CW'(cc)) +: W]} + {1'b0, b_q[off(row, CW'(cc)) +: W]};
          row_data[CW'(cc)] = ext[W-1:0];
          row_ovf = row_ovf | ext[W];
        end
        OP_SUB: begin
          ext = {1'b0, a_q[off(row, CW'(cc)) +: W]} - {1'b0, b_q[off(row, CW'(cc)) +: W]};
          row_data[CW'(cc)] = ext[W-1:0];
          row_ovf = row_ovf | ext[W];
        end
        OP_TRN:  row_data[CW'(cc)] = a_q[off(CW'(cc), row) +: W];
        default: row_data[CW'(cc)] = '0;
      endcase
    end
  end

  assign mac_en = (state == ST_RUN) && (op_q == OP_MUL);

  mat_mac #(.N(N), .W(W)) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (kk == '0),
    .en  (mac_en),
    .x   (a_q[off(row, kk) +: W]),
    .y   (b_q[off(kk, col) +: W]),
    .sum (mac_sum),
    .big (mac_big)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      work     <= '0;
      work_ovf <= 1'b0;
      row      <= '0;
      col      <= '0;
      kk       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      ovf      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            op_q     <= op_t'(op);
            row      <= '0;
            col      <= '0;
            kk       <= '0;
            work_ovf <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (op_q == OP_MUL) begin
            // k innermost, then col, then row; element written on its last term
            if (kk == LAST) begin
              work[off(row, col) +: W] <= mac_sum;
              work_ovf <= work_ovf | mac_big;
              kk <= '0;
              if (col == LAST) begin
                col <= '0;
                if (row == LAST) begin
                  busy  <= 1'b0;
                  state <= ST_DONE;
                end else begin
                  row <= row + 1'b1;
                end
              end else begin
                col <= col + 1'b1;
              end
            end else begin
              kk <= kk + 1'b1;
            end
          end else begin
            for (int unsigned cc = 0; cc < N; cc++) begin
              work[off(row, CW'(cc)) +: W] <= row_data[CW'(cc)];
            end
            work_ovf <= work_ovf | row_ovf;
            if (row == LAST) begin
              busy  <= 1'b0;
              state <= ST_DONE;
            end else begin
              row <= row + 1'b1;
            end
          end
        end
        ST_DONE: begin
          result <= work;
          ovf    <= work_ovf;
          done   <= 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mat_ops_seq.sv
// Directed self-checking bench for mat_ops_seq (N=4, W=16).
module tb_mat_ops_seq;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int FW = N * N * W;
  typedef logic [FW-1:0] mat_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] op;
  mat_t       a;
  mat_t       b;
  logic       busy;
  logic       done;
  mat_t       result;
  logic       ovf;

  int checks   = 0;
  int failures = 0;

  mat_ops_seq #(.N(N), .W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  function automatic mat_t const_mat(input logic [W-1:0] v);
    mat_t m;
    for (int i = 0; i < N * N; i++) m[i*W +: W] = v;
    return m;
  endfunction

  function automatic mat_t idx_mat(input bit transposed);
    mat_t m;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        m[(N*N-1-(r*N+c))*W +: W] = transposed ? W'(4*c + r) : W'(4*r + c);
    return m;
  endfunction

  // Starts an op (edge 0 = next posedge), scrambles inputs afterwards, waits for done.
  task automatic do_op(input logic [1:0] o, input mat_t ma, input mat_t mb, input int spur,
                       output int edone, output int ndone, output logic busy1,
                       output logic busy_done, output logic busy_after, output mat_t res_done);
    @(negedge clk);
    start = 1'b1; op = o; a = ma; b = mb;
    @(negedge clk);
    start = 1'b0; op = ~o; a = ~ma; b = ~mb;
    busy1 = busy; edone = -1; ndone = 0; busy_done = 1'b1; busy_after = 1'b0; res_done = '0;
    for (int e = 1; e <= 200 && edone < 0; e++) begin
      @(negedge clk);
      if (done) begin
        edone = e; ndone++; busy_done = busy; res_done = result;
      end
      start = (e == spur);
    end
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) ndone++;
      if (busy) busy_after = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; op = 2'd0; a = '1; b = '1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (result !== '0 || ovf !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle cycle %0d: result=%h ovf=%b busy=%b done=%b, required all 0",
                 i, result, ovf, busy, done);
      end
    end
  endtask

  task automatic test_add;
    int ed, nd; logic b1, bd, ba; mat_t rd;
    do_op(2'd0, const_mat(16'd2), const_mat(16'd4), 0, ed, nd, b1, bd, ba, rd);
    checks++; if (ed !== 5) begin failures++; $display("FAIL add_latency: got %0d required 5", ed); end
    checks++; if (b1 !== 1'b1) begin failures++; $display("FAIL add_busy: got %b required 1", b1); end
    checks++; if (bd !== 1'b0) begin failures++; $display("FAIL add_busy_at_done: got %b required 0", bd); end
    checks++; if (rd !== const_mat(16'd6)) begin failures++; $display("FAIL add_result: got %h required %h", rd, const_mat(16'd6)); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL add_ovf: got %b required 0", ovf); end
    checks++; if (nd !== 1 || ba !== 1'b0) begin failures++; $display("FAIL add_single_done: dones=%0d busy_after=%b required 1/0", nd, ba); end
  endtask

  task automatic test_mul;
    int ed, nd; logic b1, bd, ba; mat_t rd;
    do_op(2'd3, const_mat(16'd2), const_mat(16'd4), 0, ed, nd, b1, bd, ba, rd);
    checks++; if (ed !== 65) begin failures++; $display("FAIL mul_latency: got %0d required 65", ed); end
    checks++; if (rd !== const_mat(16'd32)) begin failures++; $display("FAIL mul_result: got %h required %h", rd, const_mat(16'd32)); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL mul_ovf: got %b required 0", ovf); end
    checks++; if (bd !== 1'b0) begin failures++; $display("FAIL mul_busy_at_done: got %b required 0", bd); end
  endtask

  task automatic test_sub_then_add;
    int ed, nd; logic b1, bd, ba; mat_t rd;
    do_op(2'd1, const_mat(16'd2), const_mat(16'd4), 0, ed, nd, b1, bd, ba, rd);
    checks++; if (rd !== const_mat(16'hFFFE)) begin failures++; $display("FAIL sub_result: got %h required %h", rd, const_mat(16'hFFFE)); end
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL sub_ovf: got %b required 1", ovf); end
    checks++; if (result !== const_mat(16'hFFFE)) begin failures++; $display("FAIL sub_hold: got %h required %h", result, const_mat(16'hFFFE)); end
    checks++; if (ed !== 5) begin failures++; $display("FAIL sub_latency: got %0d required 5", ed); end
    do_op(2'd0, const_mat(16'd1), const_mat(16'd1), 0, ed, nd, b1, bd, ba, rd);
    checks++; if (rd !== const_mat(16'd2)) begin failures++; $display("FAIL add2_result: got %h required %h", rd, const_mat(16'd2)); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL add2_ovf: got %b required 0", ovf); end
  endtask

  task automatic test_transpose;
    int ed, nd; logic b1, bd, ba; mat_t rd;
    mat_t junk;
    junk = {8{32'hA5C3_5A3C}};
    do_op(2'd2, idx_mat(1'b0), junk, 0, ed, nd, b1, bd, ba, rd);
    checks++; if (rd !== idx_mat(1'b1)) begin failures++; $display("FAIL trn_result: got %h required %h", rd, idx_mat(1'b1)); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL trn_ovf: got %b required 0", ovf); end
    checks++; if (ed !== 5) begin failures++; $display("FAIL trn_latency: got %0d required 5", ed); end
  endtask

  task automatic test_mul_ovf_spurious;
    int ed, nd; logic b1, bd, ba; mat_t rd;
    do_op(2'd3, const_mat(16'h0100), const_mat(16'h0100), 10, ed, nd, b1, bd, ba, rd);
    checks++; if (rd !== '0) begin failures++; $display("FAIL mulovf_result: got %h required 0", rd); end
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL mulovf_ovf: got %b required 1", ovf); end
    checks++; if (ed !== 65) begin failures++; $display("FAIL mulovf_latency: got %0d required 65", ed); end
    checks++; if (nd !== 1 || ba !== 1'b0) begin failures++; $display("FAIL mulovf_single_done: dones=%0d busy_after=%b required 1/0", nd, ba); end
  endtask

  task automatic test_reset_mid_mul;
    int ed, nd, spurious_done; logic b1, bd, ba, busy_seen; mat_t rd, exp;
    spurious_done = 0; busy_seen = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 2'd3; a = const_mat(16'd2); b = const_mat(16'd4);
    @(negedge clk);
    start = 1'b0;
    for (int e = 1; e < 30; e++) begin
      @(negedge clk);
      if (done) spurious_done++;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL midrst_outputs: busy=%b done=%b result=%h ovf=%b required all 0", busy, done, result, ovf);
    end
    rst = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done) spurious_done++;
      if (busy) busy_seen = 1'b1;
    end
    checks++; if (spurious_done !== 0) begin failures++; $display("FAIL midrst_no_done: got %0d required 0", spurious_done); end
    checks++; if (busy_seen !== 1'b0) begin failures++; $display("FAIL midrst_idle: busy seen %b required 0", busy_seen); end
    exp = '0;
    for (int i = 0; i < N * N; i++) exp[(N*N-1-i)*W +: W] = 16'hFFF0 + 16'(i);
    do_op(2'd0, idx_mat(1'b0), const_mat(16'hFFF0), 0, ed, nd, b1, bd, ba, rd);
    checks++; if (rd !== exp) begin failures++; $display("FAIL midrst_add_result: got %h required %h", rd, exp); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL midrst_add_ovf: got %b required 0", ovf); end
    checks++; if (ed !== 5) begin failures++; $display("FAIL midrst_add_latency: got %0d required 5", ed); end
  endtask

  initial begin
    test_reset;
    test_add;
    test_mul;
    test_sub_then_add;
    test_transpose;
    test_mul_ovf_spurious;
    test_reset_mid_mul;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
